// File: rtl/key_pkg.sv
// Shared types and helpers for the two-key event decoder.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        LONG,
        DB_REL
    } key_st_t;

    function automatic int ms_to_cyc(input int hz, input int ms);
        return hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchroniser, press/release debounce and
// press-duration FSM producing a first-press pulse and a long-hold level.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int LONG_CYC     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_first,
    output logic key_long
);

    localparam int CNT_MAX = (LONG_CYC > DEBOUNCE_CYC) ? LONG_CYC : DEBOUNCE_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    sync_reg;
    key_st_t       state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] rcnt_reg, rcnt_next;
    logic          first_reg, first_next;
    logic          long_reg, long_next;
    logic          s;
    logic [CW-1:0] cnt_inc;

    assign s         = ~sync_reg[1];
    assign key_first = first_reg;
    assign key_long  = long_reg;

    // Held-time counter keeps running through release debounce and saturates.
    assign cnt_inc = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b11;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rcnt_reg  <= '0;
            first_reg <= 1'b0;
            long_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_n};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rcnt_reg  <= rcnt_next;
            first_reg <= first_next;
            long_reg  <= long_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rcnt_next  = rcnt_reg;
        first_next = 1'b0;
        long_next  = long_reg;
        case (state_reg)
            IDLE: begin
                if (s) begin
                    state_next = DB_PRESS;
                    cnt_next   = CNT_ONE;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = PRESSED;
                    first_next = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            PRESSED: begin
                cnt_next = cnt_inc;
                if (!s) begin
                    state_next = DB_REL;
                    rcnt_next  = CNT_ONE;
                end else if (cnt_reg >= LONG_LAST) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                end
            end
            LONG: begin
                cnt_next = cnt_inc;
                if (!s) begin
                    state_next = DB_REL;
                    rcnt_next  = CNT_ONE;
                end
            end
            DB_REL: begin
                cnt_next = cnt_inc;
                // long_reg remembers whether we came from LONG or PRESSED.
                if (s) begin
                    state_next = long_reg ? LONG : PRESSED;
                end else if (rcnt_reg == DEB_LAST) begin
                    state_next = IDLE;
                    long_next  = 1'b0;
                end else begin
                    rcnt_next = rcnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/key_event_decoder.sv
// Two independent debounced key channels plus the registered both-keys-long event.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int IN_CLK_HZ   = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_1,
    input  logic key_n_2,
    output logic key_first_1,
    output logic key_first_2,
    output logic key_long_1,
    output logic key_long_2,
    output logic key_double_long
);

    localparam int DEBOUNCE_CYC = ms_to_cyc(IN_CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC     = ms_to_cyc(IN_CLK_HZ, LONG_MS);

    key_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LONG_CYC     (LONG_CYC)
    ) u_key_1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n_1),
        .key_first (key_first_1),
        .key_long  (key_long_1)
    );

    key_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LONG_CYC     (LONG_CYC)
    ) u_key_2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n_2),
        .key_first (key_first_2),
        .key_long  (key_long_2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_double_long <= 1'b0;
        end else begin
            key_double_long <= key_long_1 & key_long_2;
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: event-timing table, hand-written corner sequences
// and a randomized run against a run-length reference model.
module tb_key_event_decoder;

    localparam int DEB  = 4;
    localparam int LNG  = 20;
    localparam int NCYC = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_n_1 = 1'b1;
    logic key_n_2 = 1'b1;
    logic key_first_1, key_first_2, key_long_1, key_long_2, key_double_long;

    int errors = 0;
    int checks = 0;

    key_event_decoder #(
        .IN_CLK_HZ   (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_n_1         (key_n_1),
        .key_n_2         (key_n_2),
        .key_first_1     (key_first_1),
        .key_first_2     (key_first_2),
        .key_long_1      (key_long_1),
        .key_long_2      (key_long_2),
        .key_double_long (key_double_long)
    );

    always #5 clk = ~clk;

    // Observed event timing, cycle numbers counted from the last reset release.
    int cyc;
    int f1_cyc, f1_cnt, lr1, lf1, f2_cyc, f2_cnt, lr2, lf2, dr, df;

    // Reference model: debounce as run lengths of the synchronised level.
    bit m_s1[2], m_s2[2], m_pressed[2], m_long[2], m_first[2];
    int m_run[2], m_rel[2], m_age[2];
    bit m_dl;
    bit cmp_model = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1'b1; m_s2[k] = 1'b1;
            m_pressed[k] = 1'b0; m_long[k] = 1'b0; m_first[k] = 1'b0;
            m_run[k] = 0; m_rel[k] = 0; m_age[k] = 0;
        end
        m_dl = 1'b0;
    endtask

    task automatic model_step(input logic k1, input logic k2);
        bit kin[2];
        bit dl_new;
        bit s;
        kin[0] = k1;
        kin[1] = k2;
        dl_new = m_long[0] & m_long[1];
        for (int k = 0; k < 2; k++) begin
            s = ~m_s2[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = kin[k];
            m_first[k] = 1'b0;
            if (!m_pressed[k]) begin
                if (s) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_pressed[k] = 1'b1;
                        m_first[k] = 1'b1;
                        m_age[k] = 0;
                        m_rel[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end else begin
                if (m_age[k] < 1000) m_age[k]++;
                if (!s) begin
                    m_rel[k]++;
                    if (m_rel[k] == DEB) begin
                        m_pressed[k] = 1'b0;
                        m_long[k] = 1'b0;
                        m_run[k] = 0;
                    end
                end else begin
                    // A press held for LNG cycles becomes long unless a release is being debounced.
                    if (m_rel[k] == 0 && m_age[k] >= LNG) m_long[k] = 1'b1;
                    m_rel[k] = 0;
                end
            end
        end
        m_dl = dl_new;
    endtask

    task automatic obs_clear();
        cyc = 0;
        f1_cyc = -1; f1_cnt = 0; lr1 = -1; lf1 = -1;
        f2_cyc = -1; f2_cnt = 0; lr2 = -1; lf2 = -1;
        dr = -1; df = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_n_1 = 1'b1;
        key_n_2 = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_clear();
    endtask

    // Drive both raw keys for one cycle, clock, then sample and record events.
    task automatic tick(input logic k1, input logic k2);
        logic [4:0] act, exp;
        key_n_1 = k1;
        key_n_2 = k2;
        @(posedge clk);
        #1;
        cyc++;
        model_step(k1, k2);
        if (key_first_1) begin f1_cnt++; if (f1_cyc < 0) f1_cyc = cyc; end
        if (key_first_2) begin f2_cnt++; if (f2_cyc < 0) f2_cyc = cyc; end
        if (key_long_1 && lr1 < 0) lr1 = cyc;
        if (!key_long_1 && lr1 >= 0 && lf1 < 0) lf1 = cyc;
        if (key_long_2 && lr2 < 0) lr2 = cyc;
        if (!key_long_2 && lr2 >= 0 && lf2 < 0) lf2 = cyc;
        if (key_double_long && dr < 0) dr = cyc;
        if (!key_double_long && dr >= 0 && df < 0) df = cyc;
        if (cmp_model) begin
            act = {key_first_1, key_first_2, key_long_1, key_long_2, key_double_long};
            exp = {m_first[0], m_first[1], m_long[0], m_long[1], m_dl};
            check($sformatf("rand cyc%0d f1f2l1l2dl", cyc), int'(act), int'(exp));
        end
    endtask

    typedef struct {
        int s1, l1, s2, l2;
        int f1_cyc, f1_cnt, lr1, lf1;
        int f2_cyc, f2_cnt, lr2, lf2;
        int dr, df;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // start/len of each clean press, then expected first/long/double-long cycles (-1 = never)
        vecs[0] = '{0, 10, 0, 0,   6, 1, -1, -1,  -1, 0, -1, -1,  -1, -1};
        vecs[1] = '{0, 0,  0, 40, -1, 0, -1, -1,   6, 1, 26, 46,  -1, -1};
        vecs[2] = '{0, 40, 3, 40,  6, 1, 26, 46,   9, 1, 29, 49,  30, 47};
        vecs[3] = '{0, 3,  0, 0,  -1, 0, -1, -1,  -1, 0, -1, -1,  -1, -1};
        vecs[4] = '{0, 4,  0, 0,   6, 1, -1, -1,  -1, 0, -1, -1,  -1, -1};
        vecs[5] = '{0, 23, 0, 0,   6, 1, -1, -1,  -1, 0, -1, -1,  -1, -1};
        vecs[6] = '{0, 24, 0, 0,   6, 1, 26, 30,  -1, 0, -1, -1,  -1, -1};
        vecs[7] = '{5, 10, 5, 10, 11, 1, -1, -1,  11, 1, -1, -1,  -1, -1};

        do_reset();
        check("reset outputs", int'({key_first_1, key_first_2, key_long_1, key_long_2, key_double_long}), 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            for (int c = 1; c <= NCYC; c++) begin
                tick(((c - 1) >= vecs[i].s1 && (c - 1) < vecs[i].s1 + vecs[i].l1) ? 1'b0 : 1'b1,
                     ((c - 1) >= vecs[i].s2 && (c - 1) < vecs[i].s2 + vecs[i].l2) ? 1'b0 : 1'b1);
            end
            check($sformatf("v%0d first1 cyc", i), f1_cyc, vecs[i].f1_cyc);
            check($sformatf("v%0d first1 cnt", i), f1_cnt, vecs[i].f1_cnt);
            check($sformatf("v%0d long1 rise", i), lr1, vecs[i].lr1);
            check($sformatf("v%0d long1 fall", i), lf1, vecs[i].lf1);
            check($sformatf("v%0d first2 cyc", i), f2_cyc, vecs[i].f2_cyc);
            check($sformatf("v%0d first2 cnt", i), f2_cnt, vecs[i].f2_cnt);
            check($sformatf("v%0d long2 rise", i), lr2, vecs[i].lr2);
            check($sformatf("v%0d long2 fall", i), lf2, vecs[i].lf2);
            check($sformatf("v%0d dlong rise", i), dr, vecs[i].dr);
            check($sformatf("v%0d dlong fall", i), df, vecs[i].df);
            $display("vector %0d: first1=%0d long1=%0d..%0d first2=%0d long2=%0d..%0d dlong=%0d..%0d",
                     i, f1_cyc, lr1, lf1, f2_cyc, lr2, lf2, dr, df);
        end

        // Bounce: low 2, high 1, then steady low from cycle 3.
        do_reset();
        for (int c = 1; c <= 30; c++) tick((c - 1) == 2 ? 1'b1 : 1'b0, 1'b1);
        check("bounce first1 cyc", f1_cyc, 9);
        check("bounce first1 cnt", f1_cnt, 1);
        $display("bounce: first1=%0d count=%0d", f1_cyc, f1_cnt);

        // One-cycle release glitch while long-held.
        do_reset();
        for (int c = 1; c <= 60; c++) tick(((c - 1) < 40 && (c - 1) != 30) ? 1'b0 : 1'b1, 1'b1);
        check("glitch first1 cnt", f1_cnt, 1);
        check("glitch long1 rise", lr1, 26);
        check("glitch long1 fall", lf1, 46);
        $display("glitch: first1 count=%0d long1=%0d..%0d", f1_cnt, lr1, lf1);

        // Reset while key 1 is long-held; key stays held afterwards.
        do_reset();
        for (int c = 1; c <= 30; c++) tick(1'b0, 1'b1);
        check("pre-reset long1", int'(key_long_1), 1);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", int'({key_first_1, key_first_2, key_long_1, key_long_2, key_double_long}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_clear();
        for (int c = 1; c <= 30; c++) tick(1'b0, 1'b1);
        check("post-reset first1 cyc", f1_cyc, 6);
        check("post-reset first1 cnt", f1_cnt, 1);
        check("post-reset long1 rise", lr1, 26);
        $display("mid-hold reset: first1=%0d long1=%0d", f1_cyc, lr1);

        // Randomized bouncy presses on both keys against the reference model.
        begin
            int rem[2];
            logic lvl[2];
            do_reset();
            cmp_model = 1'b1;
            rem[0] = 0; rem[1] = 0;
            lvl[0] = 1'b1; lvl[1] = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                for (int k = 0; k < 2; k++) begin
                    if (rem[k] == 0) begin
                        lvl[k] = ~lvl[k];
                        rem[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                              : int'($urandom_range(6, 45));
                    end
                    rem[k]--;
                end
                tick(lvl[0], lvl[1]);
            end
            cmp_model = 1'b0;
            $display("random: %0d cycles compared against model", cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
